// File: rtl/nes_joypad_emu_if.sv
// Controller-port bus between an NES console (host) and the joypad device.
// The host drives latch and shift clock. The device returns serial data,
// where low means "pressed" at the connector.
interface nes_joypad_emu_if;
  logic pad_latch;
  logic pad_clk;
  logic pad_data;

  modport master (output pad_latch, output pad_clk, input pad_data);
  modport slave  (input pad_latch, input pad_clk, output pad_data);
endinterface

// File: rtl/nes_joypad_emu.sv
// NES controller emulation: a CD4021-style 8-bit parallel-in/serial-out
// register that answers the host joypad port. The register is loaded from
// eight debounced board pushbuttons.
// Optional feature: define JOYPAD_TURBO_EN to add turbo (auto-fire) on A and B.
module nes_joypad_emu #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TURBO_TICKS     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  nes_joypad_emu_if.slave         pad,
  input  logic [7:0]              btn_in,
  input  logic                    turbo_a,
  input  logic                    turbo_b,
  output logic [7:0]              btn_state
);

  localparam int unsigned PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    latch_sync_q;
  logic [1:0]    pclk_sync_q;
  logic          pclk_prev_q;
  logic [7:0]    btn_s1_q;
  logic [7:0]    btn_s2_q;
  logic [PW-1:0] presc_q;
  logic [7:0]    prev_q;
  logic [7:0]    btn_state_q;
  logic [7:0]    btn_state_d;
  logic [7:0]    btn_eff;
  logic [7:0]    sr_q;
  logic [3:0]    cnt_q;
  logic          tick;
  logic          pclk_rise;
  logic          latch_s;

  assign latch_s   = latch_sync_q[1];
  assign pclk_rise = pclk_sync_q[1] & ~pclk_prev_q;
  assign tick      = (presc_q == PW'(DEBOUNCE_CYCLES - 1));

  // Two-flop synchronizers for the asynchronous host pins and the buttons.
  // pclk_prev_q follows the synchronized clock at all times. A clock edge
  // that arrives while latch is high is therefore forgotten by the time the
  // latch is released.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before this edge (no simulation ordering races).
    if (rst) begin
      latch_sync_q <= '0;
      pclk_sync_q  <= '0;
      pclk_prev_q  <= 1'b0;
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
    end else begin
      latch_sync_q <= {latch_sync_q[0], pad.pad_latch};
      pclk_sync_q  <= {pclk_sync_q[0], pad.pad_clk};
      pclk_prev_q  <= pclk_sync_q[1];
      btn_s1_q     <= btn_in;
      btn_s2_q     <= btn_s1_q;
    end
  end

  // Debounce next state: on a tick, take the new sample only for bits where
  // it agrees with the previous tick's sample.
  always_comb begin
    // NOTE: default assignment first, so no path leaves btn_state_d unassigned
    // (no latch is inferred).
    btn_state_d = btn_state_q;
    if (tick) begin
      btn_state_d = (btn_s2_q & ~(btn_s2_q ^ prev_q)) |
                    (btn_state_q & (btn_s2_q ^ prev_q));
    end
  end

  // Free-running debounce prescaler with the per-tick sample history.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      prev_q      <= '0;
      btn_state_q <= '0;
    end else begin
      presc_q     <= tick ? '0 : presc_q + PW'(1);
      btn_state_q <= btn_state_d;
      if (tick) prev_q <= btn_s2_q;
    end
  end

  assign btn_state = btn_state_q;

`ifdef JOYPAD_TURBO_EN
  localparam int unsigned TW = (TURBO_TICKS > 1) ? $clog2(TURBO_TICKS) : 1;

  logic [TW-1:0] turbo_cnt_q;
  logic          phase_q;

  // Turbo phase toggles once every TURBO_TICKS debounce ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      turbo_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (tick) begin
      if (turbo_cnt_q == TW'(TURBO_TICKS - 1)) begin
        turbo_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        turbo_cnt_q <= turbo_cnt_q + TW'(1);
      end
    end
  end

  assign btn_eff = {btn_state_q[7:2],
                    btn_state_q[1] & (~turbo_b | phase_q),
                    btn_state_q[0] & (~turbo_a | phase_q)};
`else
  logic unused_turbo;
  assign unused_turbo = ^{turbo_a, turbo_b, TURBO_TICKS[0]};
  assign btn_eff      = btn_state_q;
`endif

  // Shift register and bit count. A high latch reloads the register on every
  // cycle, and that takes priority over a clock edge. After eight shifts,
  // zeros fill the register, so the connector reads pressed-level 0 from then on.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= 8'hFF;
      cnt_q <= '0;
    end else if (latch_s) begin
      sr_q  <= ~btn_eff;
      cnt_q <= '0;
    end else if (pclk_rise) begin
      sr_q  <= {1'b0, sr_q[7:1]};
      cnt_q <= (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
    end
  end

  assign pad.pad_data = sr_q[0];

endmodule

// File: tb/tb_nes_joypad_emu.sv
// Self-checking bench for nes_joypad_emu. It uses a short debounce period
// (4 cycles), table-driven button/read vectors, and directed sequences for
// the glitch, latch/clock-overlap, reset-mid-read and mid-read-change cases.
module tb_nes_joypad_emu;

  localparam int unsigned DEB   = 4;
  localparam int unsigned TTICK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn_in;
  logic       turbo_a;
  logic       turbo_b;
  logic [7:0] btn_state;

  int n_checks = 0;
  int n_fail   = 0;

  nes_joypad_emu_if pad_if ();

  nes_joypad_emu #(
    .DEBOUNCE_CYCLES(DEB),
    .TURBO_TICKS    (TTICK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pad      (pad_if),
    .btn_in   (btn_in),
    .turbo_a  (turbo_a),
    .turbo_b  (turbo_b),
    .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] btn;
    logic [7:0] exp_state;
    logic [7:0] exp_bits;   // connector level per read position, bit 0 = A
  } vec_t;

  vec_t vecs [6];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic latch_pulse();
    pad_if.pad_latch = 1'b1;
    cyc(4);
    pad_if.pad_latch = 1'b0;
    cyc(4);
  endtask

  task automatic clk_pulse();
    pad_if.pad_clk = 1'b1;
    cyc(4);
    pad_if.pad_clk = 1'b0;
    cyc(4);
  endtask

  // Full host read: latch, 8 bits, then three extra clocks that must read 0.
  task automatic read_check(input string tag, input logic [7:0] exp_bits);
    latch_pulse();
    check($sformatf("%s bit0", tag), {31'd0, pad_if.pad_data}, {31'd0, exp_bits[0]});
    for (int i = 1; i < 8; i++) begin
      clk_pulse();
      check($sformatf("%s bit%0d", tag, i), {31'd0, pad_if.pad_data}, {31'd0, exp_bits[i]});
    end
    for (int i = 8; i < 11; i++) begin
      clk_pulse();
      check($sformatf("%s extra clock %0d", tag, i + 1), {31'd0, pad_if.pad_data}, 32'd0);
    end
  endtask

  initial begin
    logic       seen;
    logic       last;
    logic       s;
    int         run;
    int         nruns;
    int         highs;

    vecs[0] = '{btn: 8'h00, exp_state: 8'h00, exp_bits: 8'hFF};
    vecs[1] = '{btn: 8'h09, exp_state: 8'h09, exp_bits: 8'hF6};
    vecs[2] = '{btn: 8'hFF, exp_state: 8'hFF, exp_bits: 8'h00};
    vecs[3] = '{btn: 8'hA5, exp_state: 8'hA5, exp_bits: 8'h5A};
    vecs[4] = '{btn: 8'h80, exp_state: 8'h80, exp_bits: 8'h7F};
    vecs[5] = '{btn: 8'h3C, exp_state: 8'h3C, exp_bits: 8'hC3};

    rst              = 1'b1;
    btn_in           = 8'h00;
    turbo_a          = 1'b0;
    turbo_b          = 1'b0;
    pad_if.pad_latch = 1'b0;
    pad_if.pad_clk   = 1'b0;
    cyc(2);
    check("reset pad_data", {31'd0, pad_if.pad_data}, 32'd1);
    check("reset btn_state", {24'd0, btn_state}, 32'h00);
    rst = 1'b0;
    cyc(2);
    read_check("reset read", 8'hFF);

    // Table-driven: settle buttons, then check debounced state and a full read.
    for (int v = 0; v < 6; v++) begin
      btn_in = vecs[v].btn;
      cyc(20);
      check($sformatf("vec%0d btn_state", v), {24'd0, btn_state}, {24'd0, vecs[v].exp_state});
      read_check($sformatf("vec%0d", v), vecs[v].exp_bits);
    end

    // A glitch lasting one tick period must not pass the debouncer.
    btn_in = 8'h00;
    cyc(20);
    seen = 1'b0;
    btn_in[0] = 1'b1;
    for (int i = 0; i < DEB; i++) begin
      cyc(1);
      seen |= btn_state[0];
    end
    btn_in[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      seen |= btn_state[0];
    end
    check("glitch filtered", {31'd0, seen}, 32'd0);

    // A clock edge while latch is high is ignored, including after release.
    btn_in = 8'h01;
    cyc(20);
    pad_if.pad_latch = 1'b1;
    cyc(4);
    pad_if.pad_clk = 1'b1;
    cyc(4);
    check("clk during latch A", {31'd0, pad_if.pad_data}, 32'd0);
    pad_if.pad_latch = 1'b0;
    cyc(4);
    check("after release A held", {31'd0, pad_if.pad_data}, 32'd0);
    pad_if.pad_clk = 1'b0;
    cyc(4);
    check("clk fall keeps A", {31'd0, pad_if.pad_data}, 32'd0);
    pad_if.pad_clk = 1'b1;
    cyc(4);
    check("first clock gives B", {31'd0, pad_if.pad_data}, 32'd1);
    pad_if.pad_clk = 1'b0;
    cyc(4);

    // Reset after three shifts restores all-released. The next read is correct.
    btn_in = 8'h09;
    cyc(20);
    latch_pulse();
    for (int i = 0; i < 3; i++) clk_pulse();
    check("pre-reset bit3 Start", {31'd0, pad_if.pad_data}, 32'd0);
    rst = 1'b1;
    cyc(1);
    check("mid-read reset pad_data", {31'd0, pad_if.pad_data}, 32'd1);
    check("mid-read reset cnt", {28'd0, dut.cnt_q}, 32'd0);
    rst = 1'b0;
    cyc(20);
    read_check("post-reset read", 8'hF6);

    // A button change during a read does not disturb the bits already loaded.
    latch_pulse();
    check("midchg bit0", {31'd0, pad_if.pad_data}, 32'd0);
    clk_pulse();
    check("midchg bit1", {31'd0, pad_if.pad_data}, 32'd1);
    btn_in = 8'hF0;
    cyc(20);
    check("midchg btn_state", {24'd0, btn_state}, 32'hF0);
    for (int i = 2; i < 8; i++) begin
      clk_pulse();
      check($sformatf("midchg bit%0d", i), {31'd0, pad_if.pad_data}, {31'd0, ((i == 3) ? 1'b0 : 1'b1)});
    end
    read_check("after midchg", 8'h0F);

    // Turbo: hold latch high so pad_data tracks the A bit continuously.
    btn_in  = 8'h01;
    turbo_a = 1'b1;
    cyc(20);
    pad_if.pad_latch = 1'b1;
    cyc(4);
`ifdef JOYPAD_TURBO_EN
    last  = pad_if.pad_data;
    run   = 1;
    nruns = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      s = pad_if.pad_data;
      if (s == last) begin
        run++;
      end else begin
        if (nruns > 0) check("turbo half-period", run, TTICK * DEB);
        nruns++;
        run  = 1;
        last = s;
      end
    end
    check("turbo toggles seen", {31'd0, (nruns >= 6)}, 32'd1);
    turbo_a = 1'b0;
    cyc(10);
`endif
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      if (pad_if.pad_data) highs++;
    end
    check("A steadily pressed", highs, 0);
    pad_if.pad_latch = 1'b0;
    turbo_a = 1'b0;
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
